rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 196 +++++++++++++++++++
 tb/tb_rob_commit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// ============================================================================
// Module   : rob_commit
// Purpose  : Reorder-buffer commit stage. Hands out tags 1..DEPTH in a
//            circular order, collects out-of-order results and retires
//            entries strictly in tag order. Entries that write a non-zero
//            register produce a registered write-back pulse.
// Options  : ROB_BYPASS_EN - when defined, a result that arrives for the
//            waiting head entry retires it in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = (2**TAG_W) - 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  input  logic              alloc_rd_en_i,
  input  logic [4:0]        alloc_rd_i,
  output logic              alloc_ready_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              res_valid_i,
  input  logic [TAG_W-1:0]  res_tag_i,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              wb_valid_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [TAG_W-1:0]  count_o
);

  // Tag 0 is reserved as "invalid"; the first usable tag is 1.
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] DEPTH_T   = TAG_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DEPTH:1]     busy_q, busy_d;
  logic [DEPTH:1]     done_q, done_d;
  logic [TAG_W-1:0]   head_q, head_d;
  logic [TAG_W-1:0]   tail_q, tail_d;
  logic [TAG_W-1:0]   count_q, count_d;
  logic               wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;

  // Per-entry payload: destination info from the decoder and the result.
  logic               rden_q [1:DEPTH];
  logic [4:0]         rd_q   [1:DEPTH];
  logic [DATA_W-1:0]  data_q [1:DEPTH];

  // --------------------------------------------------------------------------
  // Control wires
  // --------------------------------------------------------------------------
  logic               alloc_fire;
  logic [DEPTH:1]     res_we;
  logic               head_done;
  logic               head_bypass;
  logic               retire;
  logic               retire_wb;
  logic [DATA_W-1:0]  retire_data;

  // Advance a tag around the ring, skipping the invalid tag 0.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == DEPTH_T) ? TAG_FIRST : (t + TAG_FIRST);
  endfunction

  // Ready is based only on the registered count, so a same-cycle retire of a
  // full queue never opens a slot early.
  assign alloc_ready_o = (count_q < DEPTH_T);
  assign alloc_tag_o   = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign count_o    = count_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_tag_o   = wb_tag_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

  // Result capture enables: only a busy entry with a matching non-zero tag.
  always_comb begin
    res_we = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      res_we[k] = res_valid_i && (res_tag_i == TAG_W'(k)) && busy_q[k];
    end
  end

  // Head retirement decision, optionally short-circuited by a same-cycle
  // result addressed to the head entry.
  always_comb begin
    head_done = busy_q[head_q] && done_q[head_q];
`ifdef ROB_BYPASS_EN
    head_bypass = res_valid_i && busy_q[head_q] && (res_tag_i == head_q);
`else
    head_bypass = 1'b0;
`endif
    retire      = head_done || head_bypass;
    retire_data = head_done ? data_q[head_q] : res_data_i;
    retire_wb   = retire && rden_q[head_q] && (rd_q[head_q] != 5'd0);
  end

  // Next-state for pointers, occupancy, per-entry flags and write-back port.
  always_comb begin
    busy_d     = busy_q;
    done_d     = done_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wb_valid_d = 1'b0;
    wb_tag_d   = wb_tag_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (flush_i) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = TAG_FIRST;
      tail_d  = TAG_FIRST;
      count_d = '0;
    end else begin
      // Results mark their entry done (entry must already be busy).
      done_d = done_q | res_we;

      // Retire the head; clearing after the result update lets a bypassed
      // result complete and free the entry in one step.
      if (retire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = next_tag(head_q);
        if (retire_wb) begin
          wb_valid_d = 1'b1;
          wb_tag_d   = head_q;
          wb_rd_d    = rd_q[head_q];
          wb_data_d  = retire_data;
        end
      end

      // The tail entry is never busy while a grant is possible, so it cannot
      // collide with the retiring head or an accepted result.
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = next_tag(tail_q);
      end

      count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(retire);
    end
  end

  // Control state, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      done_q     <= '0;
      head_q     <= TAG_FIRST;
      tail_q     <= TAG_FIRST;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Entry payload storage; contents are only meaningful while busy is set.
  always_ff @(posedge clk_i) begin
    for (int k = 1; k <= DEPTH; k++) begin
      if (alloc_fire && (tail_q == TAG_W'(k))) begin
        rden_q[k] <= alloc_rd_en_i;
        rd_q[k]   <= alloc_rd_i;
      end
      if (res_we[k]) begin
        data_q[k] <= res_data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// ============================================================================
// Module   : tb_rob_commit
// Purpose  : Directed self-checking bench for rob_commit (default parameters).
//            Expected write-back timing follows ROB_BYPASS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_commit;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_rd_en;
  logic [4:0]        alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [DATA_W-1:0] res_data;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  // Last write-back seen by watch()
  logic [TAG_W-1:0]  seen_tag;
  logic [4:0]        seen_rd;
  logic [DATA_W-1:0] seen_data;
  int                pulses;

  rob_commit #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .alloc_valid_i (alloc_valid),
    .alloc_rd_en_i (alloc_rd_en),
    .alloc_rd_i    (alloc_rd),
    .alloc_ready_o (alloc_ready),
    .alloc_tag_o   (alloc_tag),
    .res_valid_i   (res_valid),
    .res_tag_i     (res_tag),
    .res_data_i    (res_data),
    .wb_valid_o    (wb_valid),
    .wb_tag_o      (wb_tag),
    .wb_rd_o       (wb_rd),
    .wb_data_o     (wb_data),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc1(input logic en, input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd_en = en;
    alloc_rd    = rd;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic result(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    res_valid = 1'b1;
    res_tag   = t;
    res_data  = d;
    step();
    res_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_ready", alloc_ready, 1);
    check("flush_tag", alloc_tag, 1);
  endtask

  // Count write-back pulses over a bounded window, remembering the last one.
  task automatic watch(input int cycles);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (wb_valid) begin
        pulses++;
        seen_tag  = wb_tag;
        seen_rd   = wb_rd;
        seen_data = wb_data;
      end
      step();
    end
  endtask

  logic       exp_v [0:4];
  logic [3:0] exp_t [0:4];
  logic [3:0] order [0:2];

  initial begin
    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rd_en = 1'b0;
    alloc_rd = '0; res_valid = 1'b0; res_tag = '0; res_data = '0;
    seen_tag = '0; seen_rd = '0; seen_data = '0; pulses = 0;

    // ---------------- reset ----------------
    #2;
    check("rst_count", count, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_tag", wb_tag, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", alloc_ready, 1);
    check("post_rst_tag", alloc_tag, 1);

    // ---------------- single result latency ----------------
    alloc1(1'b1, 5'd5);
    check("t1_count", count, 1);
    result(4'd1, 32'hDEAD_BEEF);
`ifndef ROB_BYPASS_EN
    check("t1_early_wb", wb_valid, 0);
    step();
`endif
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_tag", wb_tag, 1);
    check("t1_wb_rd", wb_rd, 5);
    check("t1_wb_data", wb_data, 32'hDEAD_BEEF);
    step();
    check("t1_pulse_end", wb_valid, 0);
    check("t1_hold_data", wb_data, 32'hDEAD_BEEF);
    check("t1_count_end", count, 0);

    // ---------------- out-of-order results, in-order retire ----------------
    do_flush();
    alloc1(1'b1, 5'd1);
    alloc1(1'b1, 5'd2);
    alloc1(1'b1, 5'd3);
    check("t2_count", count, 3);
    order[0] = 4'd3; order[1] = 4'd1; order[2] = 4'd2;
`ifdef ROB_BYPASS_EN
    exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 1; exp_v[3] = 1; exp_v[4] = 0;
    exp_t[0] = 0; exp_t[1] = 1; exp_t[2] = 2; exp_t[3] = 3; exp_t[4] = 0;
`else
    exp_v[0] = 0; exp_v[1] = 0; exp_v[2] = 1; exp_v[3] = 1; exp_v[4] = 1;
    exp_t[0] = 0; exp_t[1] = 0; exp_t[2] = 1; exp_t[3] = 2; exp_t[4] = 3;
`endif
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        res_valid = 1'b1;
        res_tag   = order[i];
        res_data  = 32'h100 + 32'(order[i]);
      end else begin
        res_valid = 1'b0;
      end
      step();
      check($sformatf("t2_wb_valid[%0d]", i), wb_valid, exp_v[i]);
      if (exp_v[i]) begin
        check($sformatf("t2_wb_tag[%0d]", i), wb_tag, exp_t[i]);
        check($sformatf("t2_wb_data[%0d]", i), wb_data, 32'h100 + 32'(exp_t[i]));
      end
    end
    check("t2_count_end", count, 0);

    // ---------------- full queue, commit while full ----------------
    do_flush();
    alloc_valid = 1'b1; alloc_rd_en = 1'b0; alloc_rd = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("t3_grant_tag[%0d]", i), alloc_tag, i + 1);
      step();
    end
    check("t3_full_count", count, 15);
    check("t3_full_ready", alloc_ready, 0);
    check("t3_full_tail", alloc_tag, 1);
    result(4'd1, 32'h0000_0001);
`ifndef ROB_BYPASS_EN
    check("t3_no_grant_count", count, 15);
    check("t3_still_full", alloc_ready, 0);
    step();
`endif
    check("t3_retire_count", count, 14);
    check("t3_ready_again", alloc_ready, 1);
    check("t3_wrap_tag", alloc_tag, 1);
    check("t3_no_wb", wb_valid, 0);
    step();
    alloc_valid = 1'b0;
    check("t3_refill_count", count, 15);
    check("t3_refill_tail", alloc_tag, 2);

    // ---------------- write-back suppression ----------------
    do_flush();
    alloc1(1'b0, 5'd4);
    alloc1(1'b1, 5'd0);
    alloc1(1'b1, 5'd7);
    result(4'd1, 32'hA1);
    result(4'd2, 32'hA2);
    result(4'd3, 32'hA3);
    watch(8);
    check("t4_pulses", pulses, 1);
    check("t4_wb_tag", seen_tag, 3);
    check("t4_wb_rd", seen_rd, 7);
    check("t4_wb_data", seen_data, 32'hA3);
    check("t4_count", count, 0);

    // ---------------- ignored results ----------------
    do_flush();
    alloc1(1'b1, 5'd9);
    result(4'd0, 32'hBAD0);
    result(4'd9, 32'hBAD9);
    watch(4);
    check("t5_no_wb", pulses, 0);
    check("t5_count", count, 1);
    check("t5_tail", alloc_tag, 2);
    result(4'd1, 32'h55);
    watch(4);
    check("t5_real_pulses", pulses, 1);
    check("t5_real_tag", seen_tag, 1);
    check("t5_real_rd", seen_rd, 9);
    check("t5_real_data", seen_data, 32'h55);
    check("t5_count_end", count, 0);

    // ---------------- flush mid-stream ----------------
    do_flush();
    for (int i = 0; i < 5; i++) alloc1(1'b1, 5'(i + 1));
    result(4'd2, 32'h22);
    result(4'd3, 32'h33);
    check("t6_inflight", count, 5);
    flush = 1'b1; res_valid = 1'b1; res_tag = 4'd1; res_data = 32'h11;
    alloc_valid = 1'b1; alloc_rd_en = 1'b1; alloc_rd = 5'd6;
    step();
    flush = 1'b0; res_valid = 1'b0; alloc_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_ready", alloc_ready, 1);
    check("t6_flush_tag", alloc_tag, 1);
    check("t6_flush_wb", wb_valid, 0);
    watch(6);
    check("t6_flush_pulses", pulses, 0);

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 5; i++) alloc1(1'b1, 5'(i + 1));
    result(4'd2, 32'h22);
    result(4'd3, 32'h33);
    check("t6r_inflight", count, 5);
    res_valid = 1'b1; res_tag = 4'd1; res_data = 32'h11;
    #2 rst_n = 1'b0;
    #1;
    check("t6r_async_count", count, 0);
    check("t6r_async_tag", alloc_tag, 1);
    check("t6r_async_wb", wb_valid, 0);
    res_valid = 1'b0;
    step();
    rst_n = 1'b1;
    watch(6);
    check("t6r_pulses", pulses, 0);
    check("t6r_count", count, 0);
    check("t6r_ready", alloc_ready, 1);
    check("t6r_tag", alloc_tag, 1);
    alloc1(1'b1, 5'd3);
    check("t6r_realloc_count", count, 1);
    check("t6r_realloc_tail", alloc_tag, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
